// File: rtl/rotary_pkg.sv
// Shared types and defaults for the quadrature rotary encoder decoder.
// The low two bits of each step state equal the filtered {a,b} pair.
package rotary_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int FILT_N_DEF = 4;

  typedef enum logic [2:0] {
    INIT = 3'b100,
    S00  = 3'b000,
    S01  = 3'b001,
    S11  = 3'b011,
    S10  = 3'b010
  } quad_state_t;

  function automatic quad_state_t ab_to_state(input logic [1:0] ab);
    quad_state_t s;
    case (ab)
      2'b00:   s = S00;
      2'b01:   s = S01;
      2'b11:   s = S11;
      default: s = S10;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/input_filter.sv
// Two-flop synchronizer followed by a stability filter: the output follows
// the synchronized level only after it has differed for FILT_N clocks in a row.
module input_filter #(
  parameter int FILT_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  logic       sync1_reg;
  logic       sync2_reg;
  logic [7:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      filt      <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any return to the current output level restarts the count.
      if (sync2_reg == filt) begin
        cnt_reg <= '0;
      end else if (cnt_reg == 8'(FILT_N - 1)) begin
        filt    <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder with x4 counting, illegal-jump detection
// and a debounced push-button press pulse. All outputs are registered.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FILT_N = FILT_N_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enc_sw,
  input  logic                    clr,
  output logic signed [CNT_W-1:0] pos,
  output logic                    dir,
  output logic                    step_tick,
  output logic                    err_tick,
  output logic                    press_tick
);

  localparam int INIT_CYC = FILT_N + 2;
  localparam int IW       = $clog2(INIT_CYC + 1);

  logic [2:0]    raw_vec;
  logic [2:0]    filt_vec;
  logic [1:0]    ab;
  logic [1:0]    prev_ab;
  logic [1:0]    diff;
  logic          cw;
  logic          sw_prev_reg;
  logic [IW-1:0] init_cnt_reg;
  quad_state_t   state_reg;

  assign raw_vec = {enc_sw, enc_a, enc_b};

  for (genvar gi = 0; gi < 3; gi++) begin : g_filt
    input_filter #(.FILT_N(FILT_N)) u_filt (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[gi]),
      .filt  (filt_vec[gi])
    );
  end

  assign ab      = filt_vec[1:0];
  assign prev_ab = state_reg[1:0];
  assign diff    = ab ^ prev_ab;
  // Clockwise is 00->10->11->01->00: new A always differs from old B.
  assign cw      = ab[1] ^ prev_ab[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      sw_prev_reg  <= 1'b0;
      pos          <= '0;
      dir          <= 1'b0;
      step_tick    <= 1'b0;
      err_tick     <= 1'b0;
      press_tick   <= 1'b0;
    end else begin
      step_tick   <= 1'b0;
      err_tick    <= 1'b0;
      press_tick  <= filt_vec[2] & ~sw_prev_reg;
      sw_prev_reg <= filt_vec[2];
      if (init_cnt_reg != IW'(INIT_CYC))
        init_cnt_reg <= init_cnt_reg + IW'(1);
      if (clr)
        pos <= '0;

      if (state_reg == INIT) begin
        // Wait until the filters have settled on the resting levels.
        if (init_cnt_reg == IW'(INIT_CYC))
          state_reg <= ab_to_state(ab);
      end else if (diff == 2'b11) begin
        err_tick  <= 1'b1;
        state_reg <= ab_to_state(ab);
      end else if (diff != 2'b00) begin
        step_tick <= 1'b1;
        dir       <= cw;
        state_reg <= ab_to_state(ab);
        if (!clr)
          pos <= cw ? pos + CNT_W'(1) : pos - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rotary_decoder.sv
// Scoreboard bench for rotary_decoder: each driven input change pushes the
// expected tick event; a negedge monitor pops and compares observed ticks.
module tb_rotary_decoder;
  localparam int FILT_N = 4;
  localparam int LAT    = FILT_N + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a, enc_b, enc_sw, clr;
  logic [7:0] pos;
  logic       dir, step_tick, err_tick, press_tick;

  typedef struct {
    int         cyc;
    bit         step;
    bit         err;
    bit         press;
    bit         dir;
    logic [7:0] pos;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] m_ab;
  logic [7:0] m_pos;
  bit         m_dir;

  rotary_decoder #(.CNT_W(8), .FILT_N(FILT_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_sw     (enc_sw),
    .clr        (clr),
    .pos        (pos),
    .dir        (dir),
    .step_tick  (step_tick),
    .err_tick   (err_tick),
    .press_tick (press_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (step_tick || err_tick || press_tick)) begin
      if (sb.size() == 0) begin
        check("spurious_tick", {29'd0, step_tick, err_tick, press_tick}, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("event cyc=%0d step=%0b err=%0b press=%0b dir=%0b pos=%0h", cyc,
                 step_tick, err_tick, press_tick, dir, pos);
        check("latency", cyc, e.cyc);
        check("step", {31'd0, step_tick}, {31'd0, e.step});
        check("err", {31'd0, err_tick}, {31'd0, e.err});
        check("press", {31'd0, press_tick}, {31'd0, e.press});
        check("dir", {31'd0, dir}, {31'd0, e.dir});
        check("pos", {24'd0, pos}, {24'd0, e.pos});
      end
    end
  end

  function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit fwd);
    logic [1:0] r;
    case (ab)
      2'b00:   r = fwd ? 2'b10 : 2'b01;
      2'b10:   r = fwd ? 2'b11 : 2'b00;
      2'b11:   r = fwd ? 2'b01 : 2'b10;
      default: r = fwd ? 2'b00 : 2'b11;
    endcase
    return r;
  endfunction

  // Drive new {a,b} at a negedge, predict the outcome, hold for 10 clocks.
  task automatic set_ab(input logic [1:0] v, input bit with_clr);
    exp_t       e;
    logic [1:0] d;
    @(negedge clk);
    d       = v ^ m_ab;
    e.cyc   = cyc + LAT;
    e.step  = 1'b0;
    e.err   = 1'b0;
    e.press = 1'b0;
    if (d == 2'b11) begin
      e.err = 1'b1;
    end else if (d != 2'b00) begin
      e.step = 1'b1;
      m_dir  = v[1] ^ m_ab[0];
      m_pos  = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
    end
    if (with_clr) m_pos = 8'd0;
    e.dir = m_dir;
    e.pos = m_pos;
    m_ab  = v;
    {enc_a, enc_b} = v;
    if (d != 2'b00) sb.push_back(e);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      clr = (with_clr && i == LAT - 1);
    end
    clr = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] ab_rest);
    @(negedge clk);
    reset = 1'b1;
    {enc_a, enc_b} = ab_rest;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_ab  = ab_rest;
    m_pos = 8'd0;
    m_dir = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_sw = 1'b0; clr = 1'b0;
    m_ab = 2'b00; m_pos = 8'd0; m_dir = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pos", {24'd0, pos}, 32'd0);
    check("reset_dir", {31'd0, dir}, 32'd0);
    check("reset_ticks", {29'd0, step_tick, err_tick, press_tick}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    // One full CW cycle
    set_ab(2'b10, 1'b0); set_ab(2'b11, 1'b0); set_ab(2'b01, 1'b0); set_ab(2'b00, 1'b0);
    check("cw_cycle_pos", {24'd0, pos}, 32'd4);
    check("cw_cycle_dir", {31'd0, dir}, 32'd1);

    // Bouncing A: three toggles then stable high gives a single step
    @(negedge clk); enc_a = 1'b1;
    @(negedge clk); enc_a = 1'b0;
    set_ab(2'b10, 1'b0);
    check("bounce_pos", {24'd0, pos}, 32'd5);

    // Glitch on B shorter than FILT_N clocks is ignored
    @(negedge clk); enc_b = 1'b1;
    repeat (3) @(negedge clk);
    enc_b = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_pos", {24'd0, pos}, 32'd5);

    // clr coincident with a CW step from pos=5
    set_ab(2'b11, 1'b1);
    check("clr_pos", {24'd0, pos}, 32'd0);
    check("clr_dir", {31'd0, dir}, 32'd1);

    // Two-bit jump, then a normal step
    set_ab(2'b00, 1'b0);
    check("jump_pos", {24'd0, pos}, 32'd0);
    set_ab(2'b10, 1'b0);
    check("after_jump_pos", {24'd0, pos}, 32'd1);

    // Walk CW up to 0x7F, then wrap both ways
    while (m_pos != 8'h7F) set_ab(next_ab(m_ab, 1'b1), 1'b0);
    check("pos_7f", {24'd0, pos}, 32'h7F);
    set_ab(next_ab(m_ab, 1'b1), 1'b0);
    check("wrap_up", {24'd0, pos}, 32'h80);
    set_ab(next_ab(m_ab, 1'b0), 1'b0);
    check("wrap_down", {24'd0, pos}, 32'h7F);
    check("wrap_down_dir", {31'd0, dir}, 32'd0);

    // Reset in the middle of a filter count: no tick afterwards
    @(negedge clk); enc_a = ~enc_a;
    repeat (3) @(negedge clk);
    do_reset({enc_a, enc_b});
    repeat (10) @(negedge clk);
    check("midreset_pos", {24'd0, pos}, 32'd0);

    // Reset resting at 11, then a 20-clock button press
    do_reset(2'b11);
    repeat (10) @(negedge clk);
    check("rest11_pos", {24'd0, pos}, 32'd0);
    @(negedge clk);
    enc_sw  = 1'b1;
    e.cyc   = cyc + LAT;
    e.step  = 1'b0; e.err = 1'b0; e.press = 1'b1;
    e.dir   = m_dir; e.pos = m_pos;
    sb.push_back(e);
    repeat (20) @(negedge clk);
    enc_sw = 1'b0;
    repeat (20) @(negedge clk);
    check("press_pos", {24'd0, pos}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
